// File: rtl/bf16_to_fp8_packer_if.sv
// Stream bundle for the BF16 -> FP8 packer: element input and packed-word output.
// master drives elements and consumes words; slave is the packer side.
interface bf16_to_fp8_packer_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_keep;
  logic               out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/bf16_to_fp8_packer.sv
// BF16 -> FP8 E4M3 quantizer (RNE, saturating) with a 2-stage
// register + lane packer pipeline and a saturation event counter.
module bf16_to_fp8_packer #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  bf16_to_fp8_packer_if.slave  bus,
  output logic [15:0]          sat_count
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  logic              s;
  logic [7:0]        e8;
  logic [6:0]        m7;
  logic signed [9:0] te;
  logic signed [9:0] te_r;
  logic [2:0]        kp;
  logic              rup;
  logic [3:0]        msum;
  logic              is_zero;
  logic              is_inf;
  logic              is_ovf;
  logic [7:0]        cv_byte;
  logic              cv_sat;

  always_comb begin
    s       = bus.in_data[15];
    e8      = bus.in_data[14:7];
    m7      = bus.in_data[6:0];
    te      = $signed({2'b00, e8}) - 10'sd120;
    kp      = m7[6:4];
    rup     = m7[3] & ((|m7[2:0]) | kp[0]);
    msum    = {1'b0, kp} + {3'b000, rup};
    te_r    = te + (msum[3] ? 10'sd1 : 10'sd0);
    // underflow is judged before rounding: nothing rounds up into min normal
    is_zero = (e8 == 8'h00) || (te < 10'sd1);
    is_inf  = &e8;
    is_ovf  = !is_inf && (te_r > 10'sd15);
    cv_byte = 8'h00;
    cv_sat  = 1'b0;
    unique case (1'b1)
      is_zero: begin
        cv_byte = 8'h00;
        cv_sat  = 1'b0;
      end
      is_inf, is_ovf: begin
        cv_byte = {s, 7'h7F};
        cv_sat  = 1'b1;
      end
      default: begin
        cv_byte = {s, te_r[3:0], msum[2:0]};
        cv_sat  = 1'b0;
      end
    endcase
  end

  logic       s1_valid;
  logic [7:0] s1_byte;
  logic       s1_last;
  logic       s1_sat;

  logic               out_valid_q;
  logic [8*LANES-1:0] out_data_q;
  logic [LANES-1:0]   out_keep_q;
  logic               out_last_q;
  logic [CW-1:0]      cnt;

  logic can_accept;
  logic s1_adv;
  logic in_fire;
  logic retire;
  logic wrap;

  assign can_accept = !out_valid_q || bus.out_ready;
  assign s1_adv     = s1_valid && can_accept;
  assign retire     = out_valid_q && bus.out_ready;
  assign in_fire    = bus.in_valid && bus.in_ready;
  assign wrap       = (cnt == CW'(LANES - 1)) || s1_last;

  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_byte  <= 8'h00;
      s1_last  <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_byte  <= cv_byte;
      s1_last  <= bus.in_last;
      s1_sat   <= cv_sat;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic [8*LANES-1:0] base_data;
  logic [LANES-1:0]   base_keep;
  logic [8*LANES-1:0] nxt_data;
  logic [LANES-1:0]   nxt_keep;

  // a retiring word frees the register, so the arriving byte starts clean
  always_comb begin
    base_data = retire ? '0 : out_data_q;
    base_keep = retire ? '0 : out_keep_q;
    nxt_data  = base_data;
    nxt_keep  = base_keep;
    nxt_data[8*int'(cnt) +: 8] = s1_byte;
    nxt_keep[cnt]              = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      cnt         <= '0;
    end else if (s1_adv) begin
      out_data_q <= nxt_data;
      out_keep_q <= nxt_keep;
      if (wrap) begin
        out_valid_q <= 1'b1;
        out_last_q  <= s1_last;
        cnt         <= '0;
      end else begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        cnt         <= cnt + CW'(1);
      end
    end else if (retire) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= 16'h0000;
    end else if (clear) begin
      sat_count <= 16'h0000;
    end else if (s1_adv && s1_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end
endmodule

// File: tb/tb_bf16_to_fp8_packer.sv
// Directed bench for bf16_to_fp8_packer: real-valued nearest-even
// reference quantizer, word packing model and per-handshake compare.
module tb_bf16_to_fp8_packer;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] sat_count;

  bf16_to_fp8_packer_if #(.LANES(LANES)) bus ();

  bf16_to_fp8_packer #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*LANES-1:0] d;
    logic [LANES-1:0]   k;
    logic               l;
  } word_t;

  word_t              q[$];
  int                 total = 0;
  int                 passes = 0;
  int                 exp_sat = 0;
  int                 mcnt = 0;
  logic [8*LANES-1:0] mw_data = '0;
  logic [LANES-1:0]   mw_keep = '0;
  int                 nwords = 0;
  int                 waits = 0;
  logic [8*LANES-1:0] last_data = '0;
  logic [LANES-1:0]   last_keep = '0;
  logic               last_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic real fp8_val(input int c);
    int e;
    int m;
    e = (c >> 3) & 15;
    m = c & 7;
    return (2.0 ** real'(e - 7)) * (1.0 + real'(m) / 8.0);
  endfunction

  // nearest representable magnitude, ties to even code; 512 stands in
  // for the first value past the top of the format
  function automatic void model(input logic [15:0] x, output logic [7:0] b,
                                output bit sat);
    logic       sg;
    int         e8;
    int         m7;
    real        a;
    real        v;
    real        d;
    real        bd;
    int         best;
    logic [7:0] bc;
    sg  = x[15];
    e8  = int'(x[14:7]);
    m7  = int'(x[6:0]);
    b   = 8'h00;
    sat = 1'b0;
    if (e8 == 0) begin
      b = 8'h00;
    end else if (e8 == 255) begin
      b   = {sg, 7'h7F};
      sat = 1'b1;
    end else begin
      a = (1.0 + real'(m7) / 128.0) * (2.0 ** real'(e8 - 127));
      if (a < 2.0 ** -6.0) begin
        b = 8'h00;
      end else begin
        best = -1;
        bd   = 0.0;
        for (int c = 8; c <= 128; c++) begin
          v = (c == 128) ? 512.0 : fp8_val(c);
          d = (a > v) ? a - v : v - a;
          if (best < 0 || d < bd || (d == bd && (c % 2) == 0)) begin
            best = c;
            bd   = d;
          end
        end
        if (best == 128) begin
          b   = {sg, 7'h7F};
          sat = 1'b1;
        end else begin
          bc = 8'(best);
          b  = {sg, bc[6:0]};
        end
      end
    end
  endfunction

  task automatic model_push(input logic [15:0] d, input bit l);
    logic [7:0] b;
    bit         st;
    word_t      w;
    model(d, b, st);
    if (st) exp_sat++;
    mw_data[8*mcnt +: 8] = b;
    mw_keep[mcnt]        = 1'b1;
    mcnt++;
    if (mcnt == LANES || l) begin
      w.d = mw_data;
      w.k = mw_keep;
      w.l = l;
      q.push_back(w);
      mcnt    = 0;
      mw_data = '0;
      mw_keep = '0;
    end
  endtask

  task automatic send(input logic [15:0] d, input bit l);
    int w;
    w            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && w <= 100) begin
      w++;
      waits++;
      @(negedge clk);
    end
    if (w > 100) begin
      chk("in_ready_timeout", 64'(w), 64'd0);
      bus.in_valid = 1'b0;
    end else begin
      model_push(d, l);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q.size() != 0 || bus.out_valid) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_done", 64'(i < 200), 64'd1);
  endtask

  logic               stall_prev = 1'b0;
  logic [8*LANES-1:0] prev_data;
  logic [LANES-1:0]   prev_keep;
  logic               prev_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_stable",
            {27'd0, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data},
            {27'd0, 1'b1, prev_last, prev_keep, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 64'(bus.out_data), 64'd0);
          chk("extra_word_q", 64'd1, 64'(q.size()));
        end else begin
          word_t w;
          w = q.pop_front();
          chk("word_data", 64'(bus.out_data), 64'(w.d));
          chk("word_keep", 64'(bus.out_keep), 64'(w.k));
          chk("word_last", 64'(bus.out_last), 64'(w.l));
        end
        last_data = bus.out_data;
        last_keep = bus.out_keep;
        last_last = bus.out_last;
        nwords++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pb;
    bit          ps;
    logic [15:0] bp_vals[12];
    logic [15:0] sv;
    int          n0;
    bit          saw_low;

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    model(16'h3F98, pb, ps);
    chk("pin_3F98", {55'd0, ps, pb}, {55'd0, 1'b0, 8'h3A});
    model(16'h43FA, pb, ps);
    chk("pin_43FA", {55'd0, ps, pb}, {55'd0, 1'b1, 8'h7F});
    model(16'h3B80, pb, ps);
    chk("pin_3B80", {55'd0, ps, pb}, {55'd0, 1'b0, 8'h00});
    model(16'hC000, pb, ps);
    chk("pin_C000", {55'd0, ps, pb}, {55'd0, 1'b0, 8'hC0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_keep", 64'(bus.out_keep), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_sat", 64'(sat_count), 64'd0);
    @(posedge clk);
    #1;

    send(16'h3F80, 1'b0);
    send(16'hC000, 1'b0);
    send(16'h3F88, 1'b0);
    send(16'h3F98, 1'b0);
    chk("lat_edge_n", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_edge_n1", 64'(bus.out_valid), 64'd1);
    drain();
    chk("conv_word", 64'(last_data), 64'h3A38C038);
    chk("conv_keep", 64'(last_keep), 64'hF);
    chk("conv_sat", 64'(sat_count), 64'd0);

    send(16'h43F0, 1'b0);
    send(16'h43FA, 1'b0);
    send(16'hFF80, 1'b0);
    send(16'h3B80, 1'b0);
    drain();
    chk("sat_word", 64'(last_data), 64'h00FF7F7F);
    chk("sat_count2", 64'(sat_count), 64'd2);
    chk("sat_model", 64'(sat_count), 64'(exp_sat));

    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    drain();
    chk("part_word", 64'(last_data), 64'h00004038);
    chk("part_keep", 64'(last_keep), 64'h3);
    chk("part_last", 64'(last_last), 64'd1);

    bp_vals = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080,
                16'hBF80, 16'hC000, 16'h3E00, 16'h3E80,
                16'h4100, 16'h4180, 16'h3FC0, 16'h3FA0};
    n0      = nwords;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(bp_vals[i], 1'b0);
      end
      begin
        @(posedge clk);
        #2 bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (!bus.in_ready) saw_low = 1'b1;
          @(posedge clk);
        end
        #2 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_low", 64'(saw_low), 64'd1);
    chk("bp_words", 64'(nwords - n0), 64'd3);

    n0    = nwords;
    waits = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) sv = 16'h7F80;
      else if (i % 8 == 7) sv = {1'b1, 8'hFF, 7'h00};
      else sv = {1'(i % 3 == 0), 8'(121 + (i % 16)), 7'(i * 13)};
      send(sv, 1'b0);
    end
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_sat = 0;
    drain();
    chk("stream_no_stall", 64'(waits), 64'd0);
    chk("stream_words", 64'(nwords - n0), 64'd16);
    chk("stream_clear", 64'(sat_count), 64'(exp_sat));

    send(16'h43FA, 1'b0);
    send(16'h3F80, 1'b0);
    rst = 1'b1;
    mcnt    = 0;
    mw_data = '0;
    mw_keep = '0;
    exp_sat = 0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_keep", 64'(bus.out_keep), 64'd0);
    chk("mid_rst_last", 64'(bus.out_last), 64'd0);
    chk("mid_rst_sat", 64'(sat_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(16'h3F80, 1'b0);
    send(16'hC000, 1'b0);
    send(16'h3F88, 1'b0);
    send(16'h3F98, 1'b0);
    drain();
    chk("post_rst_word", 64'(last_data), 64'h3A38C038);
    chk("post_rst_keep", 64'(last_keep), 64'hF);
    chk("post_rst_q", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/bf16_to_fp8_packer.md
# bf16_to_fp8_packer

Output-side quantizer for the systolic array. Accepts a stream of BF16 results drained from PE `c_out`, converts each value to FP8 E4M3 in the same encoding the PEs decode, and packs LANES bytes per output word for write-back. The block is a 2-stage pipeline with valid/ready handshakes on both sides and a saturation event counter.

## Interface
- `LANES`, 4: FP8 bytes per output word; legal range 1..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `clear`  in  1  synchronous; zeroes `sat_count` only.
- `in_valid`  in  1  `in_data`/`in_last` valid.
- `in_ready`  out  1  block accepts an element this cycle.
- `in_data`  in  16  BF16 value.
- `in_last`  in  1  final element of a tile; forces a word flush.
- `out_valid`  out  1  `out_data` word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  8*LANES  packed FP8; first element in `[7:0]`.
- `out_keep`  out  LANES  per-byte valid mask.
- `out_last`  out  1  word contains the `in_last` element.
- `sat_count`  out  16  saturation events; sticks at 16'hFFFF.

## Operation
- BF16 fields: `s=in_data[15]`, `e8=in_data[14:7]`, `m7=in_data[6:0]`. Target exponent `te = e8 - 120`, signed, at least 10 bits wide.
- `e8==0` (zero or subnormal) produces 8'h00.
- `e8==255` (inf or NaN) produces `{s,7'h7F}` and counts as a saturation.
- Otherwise, round to nearest even.
  - keep = `m7[6:4]`, guard = `m7[3]`, sticky = `|m7[2:0]`.
  - Round up iff `guard & (sticky | keep[0])`.
  - A mantissa carry out (111+1) gives mantissa 000 and `te+1`.
- After rounding:
  - `te > 15` produces `{s,7'h7F}` (max magnitude 480) and counts as a saturation.
  - `te < 1` produces 8'h00. There is no subnormal output and no rounding up into the minimum normal.
  - Else the result is `{s, te[3:0], mant3}`.
- Stage 1 (S1) is a register holding the converted byte, its valid bit, its last bit and its saturation flag.
- Stage 2 is the packer: lane counter `cnt`, 0..LANES-1, plus the output register.
  - When an S1 byte moves, it is written to lane `cnt` and `keep[cnt]` is set.
  - If `cnt==LANES-1` or the byte carries last, `out_valid` is set, `out_last` takes the byte's last bit, and `cnt` returns to 0. Otherwise `cnt` increments.
- The packer can accept when `!out_valid || out_ready`. On a handshake (`out_valid && out_ready`), the word is retired. A byte arriving in the same cycle starts a fresh word in lane 0, with `keep` reset to that one bit.
- Unused bytes of a partial word read 8'h00 and have `keep=0`.
- Handshake signals:
  - S1 advances when `s1_valid && packer_can_accept`.
  - `in_ready = !s1_valid || (s1 advance)`, combinational, with no combinational path from `in_valid`.
  - `out_data`, `out_keep`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`.
- `sat_count` increments by 1 when a saturating S1 byte moves into the packer. `clear` takes priority over a same-cycle increment.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`, `sat_count=0`.
  - S1 empty, `cnt=0`.
  - `in_ready=1` in the first cycle after reset deasserts.
- Latency: element accepted at edge N is in S1 after N and in the packer after N+1. For a word-completing element, `out_valid` is high in the cycle after edge N+1.
- Throughput: 1 element/cycle with `out_ready` held high, including back-to-back words.
- Backpressure: with `out_ready` held low, at most 1 word plus 1 S1 byte are buffered, then `in_ready=0`. No element is dropped or duplicated.
- Reset asserted mid-stream discards the partial word and S1 immediately, asynchronously.

## Test plan
- Conversions, `LANES=4`, `in_ready`/`out_ready` high, inputs 0x3F80, 0xC000, 0x3F88, 0x3F98 -> one word `out_data=32'h3A38C038`, `keep=4'hF`, valid 2 cycles after the 4th accept, `sat_count=0`.
- Saturation and flush, inputs 0x43F0, 0x43FA, 0xFF80, 0x3B80 (2^-8) -> bytes 7F, 7F, FF, 00 -> word 32'h00FF7F7F, `sat_count=2`.
- Partial flush: 0x3F80 and 0x4000 with `in_last` on the second -> word 32'h00004038, `keep=4'h3`, `out_last=1`; the next word starts at lane 0.
- Backpressure: 12-element stream with `out_ready` low 5 cycles mid-word -> `in_ready` drops, output stable while stalled, 3 words in order, none lost.
- Streaming: 64 back-to-back elements, `out_ready` high -> 16 words on consecutive cycles; `clear` pulsed in the same cycle as a saturation -> `sat_count=0`.
- Reset mid-word after 2 accepts -> all outputs return to reset values, and the next 4 elements form a fresh word.
